// File: rtl/cpa_final_stage.sv
// Resolves the sum/carry rows of the approximate 8x8 multiplier into the binary product over two pipeline stages.
// One cycle from accept to out_valid; a stalled output stage holds its data, and in_ready drops once both stages are full.
module cpa_final_stage #(
    parameter int W     = 16,
    parameter int SPLIT = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_sum,
    input  logic [W-1:0]     in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_prod,
    output logic             out_ovf,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int HW = W - SPLIT;

    logic             r_s1_vld;
    logic [SPLIT-1:0] r_s1_lo;
    logic             r_s1_c_lo;
    logic [HW-1:0]    r_s1_sum_hi;
    logic [HW-1:0]    r_s1_carry_hi;

    logic             r_s2_vld;
    logic [W-1:0]     r_prod;
    logic             r_ovf;
    logic [CNT_W-1:0] r_done_cnt;

    logic [SPLIT:0]   w_lo;
    logic [HW:0]      w_hi;
    logic             w_s2_adv;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // Low-half add happens before the register so only the short high half remains for stage 2.
    assign w_lo = {1'b0, in_sum[SPLIT-1:0]} + {1'b0, in_carry[SPLIT-1:0]};
    assign w_hi = {1'b0, r_s1_sum_hi} + {1'b0, r_s1_carry_hi} + {{HW{1'b0}}, r_s1_c_lo};

    assign w_s2_adv   = r_s1_vld & (~r_s2_vld | out_ready);
    assign in_ready   = ~r_s1_vld | w_s2_adv;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_s2_vld & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld      <= 1'b0;
            r_s1_lo       <= '0;
            r_s1_c_lo     <= 1'b0;
            r_s1_sum_hi   <= '0;
            r_s1_carry_hi <= '0;
        end else begin
            r_s1_vld <= w_in_xfer | (r_s1_vld & ~w_s2_adv);
            if (w_in_xfer) begin
                r_s1_lo       <= w_lo[SPLIT-1:0];
                r_s1_c_lo     <= w_lo[SPLIT];
                r_s1_sum_hi   <= in_sum[W-1:SPLIT];
                r_s1_carry_hi <= in_carry[W-1:SPLIT];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_prod   <= '0;
            r_ovf    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_vld <= 1'b1;
            r_prod   <= {w_hi[HW-1:0], r_s1_lo};
            r_ovf    <= w_hi[HW];
        end else if (w_out_xfer) begin
            r_s2_vld <= 1'b0;
        end
    end

    // Saturates rather than wraps so long characterisation runs never under-report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_cnt <= '0;
        end else if (w_out_xfer && (r_done_cnt != {CNT_W{1'b1}})) begin
            r_done_cnt <= r_done_cnt + 1'b1;
        end
    end

    assign out_valid = r_s2_vld;
    assign out_prod  = r_prod;
    assign out_ovf   = r_ovf;
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_cpa_final_stage.sv
// Directed bench for cpa_final_stage: inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_cpa_final_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sum;
    logic [15:0] in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic        out_ovf;
    logic [15:0] done_cnt;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;
    logic [16:0] exp_q[$];
    int          out_cyc[$];
    logic [16:0] e;

    cpa_final_stage #(.W(16), .SPLIT(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_ovf   (out_ovf),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted pair must come out once, in order, with the exact 17-bit sum.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                exp_q.push_back({1'b0, in_sum} + {1'b0, in_carry});
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_prod), 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_prod", 32'(out_prod), 32'(e[15:0]));
                    check("sb_ovf", 32'(out_ovf), 32'(e[16]));
                end
            end
        end
    end

    task automatic send(input logic [15:0] s, input logic [15:0] c);
        bit ok;
        ok = 1'b0;
        in_sum   = s;
        in_carry = c;
        in_valid = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            check("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; in_carry = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_prod", 32'(out_prod), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        check("rst_cnt", 32'(done_cnt), 32'd0);

        // Full wrap of the 16-bit sum, one-cycle latency
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_prod", 32'(out_prod), 32'h0000);
        check("t1_ovf", 32'(out_ovf), 32'd1);
        @(negedge clk);
        check("t1_cnt", 32'(done_cnt), 32'd1);
        check("t1_empty", 32'(out_valid), 32'd0);

        // Carry out of the low half into the high half
        @(posedge clk); #1;
        send(16'h00FF, 16'h0001);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_prod", 32'(out_prod), 32'h0100);
        check("t2_ovf", 32'(out_ovf), 32'd0);
        drain();
        check("t2_cnt", 32'(done_cnt), 32'd2);

        // Backpressure: A and B fill both stages, C waits
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h1234, 16'h4321);
        send(16'h8000, 16'h8000);
        fork
            send(16'h00F0, 16'h0F10);
            begin
                @(negedge clk);
                check("t3_full_rdy", 32'(in_ready), 32'd0);
                check("t3_head_prod", 32'(out_prod), 32'h5555);
                @(negedge clk);
                check("t3_still_full", 32'(in_ready), 32'd0);
                check("t3_hold_prod", 32'(out_prod), 32'h5555);
                check("t3_hold_vld", 32'(out_valid), 32'd1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_b_prod", 32'(out_prod), 32'h0000);
        check("t3_b_ovf", 32'(out_ovf), 32'd1);
        @(negedge clk);
        check("t3_c_prod", 32'(out_prod), 32'h1000);
        drain();
        check("t3_cnt", 32'(done_cnt), 32'd5);

        // Reset with two entries in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h0101, 16'h0202);
        send(16'h0303, 16'h0404);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_prod", 32'(out_prod), 32'd0);
        check("t5_cnt", 32'(done_cnt), 32'd0);
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t5_no_ghost", 32'(out_valid), 32'd0);
        end

        // Ten back-to-back random pairs at full throughput
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++)
            send(16'($urandom), 16'($urandom));
        drain();
        check("t4_cnt", 32'(done_cnt), 32'd10);
        check("t4_nout", 32'(out_cyc.size()), 32'd15);
        if (out_cyc.size() >= 10)
            check("t4_back2back", 32'(out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-10]), 32'd9);

        // Counter saturation
        @(posedge clk); #1;
        force dut.r_done_cnt = 16'hFFFE;
        #1 release dut.r_done_cnt;
        @(negedge clk);
        check("t6_preload", 32'(done_cnt), 32'hFFFE);
        @(posedge clk); #1;
        send(16'h0001, 16'h0002);
        send(16'h7FFF, 16'h8001);
        send(16'hAAAA, 16'h5555);
        drain();
        check("t6_sat", 32'(done_cnt), 32'hFFFF);
        @(posedge clk); #1;
        send(16'h0010, 16'h0020);
        drain();
        check("t6_hold", 32'(done_cnt), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
